pc_sequencer: RTL and testbench

//  Multicycle fetch/execute sequencer that owns the program counter's write enable (PCWire) and next-PC value.

---
 rtl/pc_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute sequencer: drives the PC write strobe and the next-PC value.
// Optional PC range check and sticky trap are enabled by defining PC_BOUND_CHECK_EN.
module pc_sequencer #(
  parameter int              PC_W         = 64,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter int              PC_INC       = 4,
  parameter logic [PC_W-1:0] IMEM_BYTES   = 64'h400,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = 64'h3FC
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            run,
  input  logic [PC_W-1:0] pc_cur,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic            exec_valid,
  input  logic            branch_uncond,
  input  logic            branch_cond,
  input  logic            alu_zero,
  input  logic            halt,
  input  logic [PC_W-1:0] branch_offset,
  output logic            pc_write,
  output logic [PC_W-1:0] pc_next,
  output logic [2:0]      state,
  output logic [31:0]     retired_count,
  output logic            trap
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] PC_INC_EXT = PC_W'(PC_INC);

  // A trap vector outside instruction memory would re-trap forever.
  if (TRAP_VECTOR >= IMEM_BYTES) begin : g_bad_trap_vector
    $error("pc_sequencer: TRAP_VECTOR must lie below IMEM_BYTES");
  end

  state_t          state_q, state_d;
  logic            imem_req_q;
  logic [PC_W-1:0] pc_next_q;
  logic [31:0]     retired_q;

  // Instruction fields captured when the execute stage resolves.
  logic            lat_uncond;
  logic            lat_cond;
  logic            lat_zero;
  logic [PC_W-1:0] lat_offset;
  logic [PC_W-1:0] lat_pc;

  logic            taken;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] update_value;
  logic            exec_fire;

  assign exec_fire = (state_q == S_EXEC) && exec_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_INIT;
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_EXEC;
      S_EXEC:   if (exec_valid) state_d = halt ? S_HALTED : S_UPDATE;
      S_UPDATE: state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= (state_d == S_FETCH);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture and target computation
  // ---------------------------------------------------------------------------
  // NOTE: these capture registers are reset too, so a reset mid-instruction
  // cannot leak a stale target into the next run.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      lat_uncond <= 1'b0;
      lat_cond   <= 1'b0;
      lat_zero   <= 1'b0;
      lat_offset <= '0;
      lat_pc     <= '0;
    end else if (exec_fire) begin
      lat_uncond <= branch_uncond;
      lat_cond   <= branch_cond;
      lat_zero   <= alu_zero;
      lat_offset <= branch_offset;
      lat_pc     <= pc_cur;
    end
  end

  // Unconditional branch dominates; addition wraps modulo 2^PC_W by design.
  assign taken  = lat_uncond | (lat_cond & lat_zero);
  assign target = lat_pc + (taken ? (lat_offset << 2) : PC_INC_EXT);

`ifdef PC_BOUND_CHECK_EN
  logic out_of_range;
  logic trap_q;

  assign out_of_range = (target >= IMEM_BYTES);
  assign update_value = out_of_range ? TRAP_VECTOR : target;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      trap_q <= 1'b0;
    end else if ((state_q == S_UPDATE) && out_of_range) begin
      trap_q <= 1'b1;
    end
  end

  // Visible during the redirecting UPDATE cycle, then held by trap_q.
  assign trap = trap_q | ((state_q == S_UPDATE) && out_of_range);
`else
  assign update_value = target;
  assign trap         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // PC write strobe, next-PC hold register and retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_next_q <= '0;
      retired_q <= '0;
    end else begin
      unique case (state_q)
        S_INIT:   pc_next_q <= RESET_VECTOR;
        S_UPDATE: begin
          pc_next_q <= update_value;
          retired_q <= retired_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_write = 1'b0;
    pc_next  = pc_next_q;
    unique case (state_q)
      S_INIT: begin
        pc_write = 1'b1;
        pc_next  = RESET_VECTOR;
      end
      S_UPDATE: begin
        pc_write = 1'b1;
        pc_next  = update_value;
      end
      default: ;
    endcase
  end

  assign imem_req      = imem_req_q;
  assign state         = state_q;
  assign retired_count = retired_q;

  // INIT and UPDATE are never adjacent, so the strobe can never stretch.
  a_pc_write_single : assert property (
    @(posedge CLOCK) disable iff (RESET) pc_write |=> !pc_write
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of instructions with hand-computed targets,
// plus hand-written reset-in-EXEC and halt sequences.
module tb_pc_sequencer;

  localparam int PC_W = 64;

  logic            CLOCK = 1'b0;
  logic            RESET;
  logic            run;
  logic [PC_W-1:0] pc_cur;
  logic            imem_req;
  logic            imem_ack;
  logic            exec_valid;
  logic            branch_uncond;
  logic            branch_cond;
  logic            alu_zero;
  logic            halt;
  logic [PC_W-1:0] branch_offset;
  logic            pc_write;
  logic [PC_W-1:0] pc_next;
  logic [2:0]      state;
  logic [31:0]     retired_count;
  logic            trap;

  pc_sequencer dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .run           (run),
    .pc_cur        (pc_cur),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .exec_valid    (exec_valid),
    .branch_uncond (branch_uncond),
    .branch_cond   (branch_cond),
    .alu_zero      (alu_zero),
    .halt          (halt),
    .branch_offset (branch_offset),
    .pc_write      (pc_write),
    .pc_next       (pc_next),
    .state         (state),
    .retired_count (retired_count),
    .trap          (trap)
  );

  always #5 CLOCK = ~CLOCK;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic [63:0] pc;
    logic        bu;
    logic        bc;
    logic        zero;
    logic [63:0] offset;
    logic [63:0] target;   // raw branch/sequential target, before any range check
    int          ack_dly;
    int          exec_dly;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] exp_pc;
  logic        exp_trap = 1'b0;
  logic [31:0] exp_retired = 32'd0;

  task automatic drive_idle_inputs();
    imem_ack      = 1'b0;
    exec_valid    = 1'b0;
    branch_uncond = 1'b0;
    branch_cond   = 1'b0;
    alu_zero      = 1'b0;
    halt          = 1'b0;
    branch_offset = '0;
    pc_cur        = '0;
  endtask

  // Entered at a negedge with the DUT in IDLE; leaves at a negedge in FETCH.
  task automatic start_run();
    run = 1'b1;
    @(negedge CLOCK);
    check("init_state", 64'(state), 64'd1);
    check("init_pc_write", 64'(pc_write), 64'd1);
    check("init_pc_next", pc_next, 64'h0);
    check("init_retired", 64'(retired_count), 64'(exp_retired));
    run = 1'b0;
    @(negedge CLOCK);
    check("fetch_state", 64'(state), 64'd2);
    check("fetch_imem_req", 64'(imem_req), 64'd1);
    check("fetch_pc_write", 64'(pc_write), 64'd0);
  endtask

  // Entered at a negedge in FETCH; leaves at a negedge in EXEC.
  task automatic fetch(input int ack_dly);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0;
      @(negedge CLOCK);
      check("fetch_wait_state", 64'(state), 64'd2);
      check("fetch_wait_req", 64'(imem_req), 64'd1);
    end
    imem_ack = 1'b1;
    @(negedge CLOCK);
    imem_ack = 1'b0;
    check("exec_state", 64'(state), 64'd3);
    check("exec_imem_req", 64'(imem_req), 64'd0);
  endtask

  // One full instruction from FETCH through UPDATE back to FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    fetch(v.ack_dly);
    pc_cur        = v.pc;
    branch_uncond = v.bu;
    branch_cond   = v.bc;
    alu_zero      = v.zero;
    branch_offset = v.offset;
    for (int i = 0; i < v.exec_dly; i++) begin
      @(negedge CLOCK);
      check("exec_wait_state", 64'(state), 64'd3);
      check("exec_wait_pc_write", 64'(pc_write), 64'd0);
    end
    exec_valid = 1'b1;
    @(negedge CLOCK);
    exec_valid = 1'b0;
    // Scramble inputs: the target must come from the captured operands.
    pc_cur        = 64'hDEAD_BEEF_0000_1230;
    branch_uncond = ~v.bu;
    branch_offset = 64'h55;
    exp_pc = v.target;
`ifdef PC_BOUND_CHECK_EN
    if (v.target >= 64'h400) begin
      exp_pc   = 64'h3FC;
      exp_trap = 1'b1;
    end
`endif
    check($sformatf("v%0d_update_state", idx), 64'(state), 64'd4);
    check($sformatf("v%0d_pc_write", idx), 64'(pc_write), 64'd1);
    check($sformatf("v%0d_pc_next", idx), pc_next, exp_pc);
    check($sformatf("v%0d_trap", idx), 64'(trap), 64'(exp_trap));
    exp_retired++;
    @(negedge CLOCK);
    check($sformatf("v%0d_pc_write_drop", idx), 64'(pc_write), 64'd0);
    check($sformatf("v%0d_pc_next_hold", idx), pc_next, exp_pc);
    check($sformatf("v%0d_retired", idx), 64'(retired_count), 64'(exp_retired));
    check($sformatf("v%0d_back_fetch", idx), 64'(state), 64'd2);
    check($sformatf("v%0d_trap_hold", idx), 64'(trap), 64'(exp_trap));
  endtask

  initial begin
    vecs[0] = '{64'h10,  1'b0, 1'b0, 1'b0, 64'd0,  64'h14, 3, 2};
    vecs[1] = '{64'h40,  1'b0, 1'b1, 1'b0, 64'd5,  64'h44, 0, 0};
    vecs[2] = '{64'h40,  1'b0, 1'b1, 1'b1, -64'sd4, 64'h30, 1, 1};
    vecs[3] = '{64'h40,  1'b1, 1'b1, 1'b0, 64'd2,  64'h48, 0, 3};
    vecs[4] = '{64'h100, 1'b1, 1'b0, 1'b0, 64'h10, 64'h140, 2, 0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 64'd7, 64'h0, 0, 1};
    vecs[6] = '{64'h3FC, 1'b1, 1'b0, 1'b0, 64'd1,  64'h400, 1, 0};
    vecs[7] = '{64'h8,   1'b1, 1'b0, 1'b1, -64'sd4, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0};

    RESET = 1'b1;
    run   = 1'b0;
    drive_idle_inputs();
    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_pc_write", 64'(pc_write), 64'd0);
    check("rst_pc_next", pc_next, 64'h0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);

    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    check("idle_wait_state", 64'(state), 64'd0);
    start_run();

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of an EXEC cycle.
    fetch(1);
    pc_cur = 64'h200;
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst_state", 64'(state), 64'd0);
    check("async_rst_pc_write", 64'(pc_write), 64'd0);
    check("async_rst_pc_next", pc_next, 64'h0);
    check("async_rst_retired", 64'(retired_count), 64'd0);
    check("async_rst_trap", 64'(trap), 64'd0);
    check("async_rst_imem_req", 64'(imem_req), 64'd0);
    exp_retired = 32'd0;
    exp_trap    = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b0;
    exec_valid = 1'b1;
    imem_ack   = 1'b1;
    @(negedge CLOCK);
    check("post_rst_exec_ignored_state", 64'(state), 64'd0);
    check("post_rst_exec_ignored_pc_write", 64'(pc_write), 64'd0);
    check("post_rst_exec_ignored_retired", 64'(retired_count), 64'd0);
    drive_idle_inputs();

    start_run();
    run_vec(8, vecs[0]);

    // Halting instruction: no UPDATE, not counted, stuck until reset.
    fetch(0);
    halt       = 1'b1;
    exec_valid = 1'b1;
    pc_cur     = 64'h80;
    @(negedge CLOCK);
    exec_valid = 1'b0;
    halt       = 1'b0;
    imem_ack   = 1'b1;
    run        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("halted_state", 64'(state), 64'd5);
      check("halted_pc_write", 64'(pc_write), 64'd0);
      check("halted_imem_req", 64'(imem_req), 64'd0);
      check("halted_retired", 64'(retired_count), 64'(exp_retired));
      check("halted_pc_next_hold", pc_next, 64'h14);
      @(negedge CLOCK);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
